// File: rtl/display_scanout.sv
// display_scanout: reads a 64x32 monochrome framebuffer from memory one byte
// at a time and streams it as pixels (MSB first) over a valid/ready port.
// Optional build macro SCANOUT_PREFETCH_EN: while the current byte is being
// shifted out, the next byte is fetched into a one-entry buffer so that the
// pixel stream has no bubbles between bytes.
module display_scanout #(
    parameter logic [11:0] FB_OFFSET = 12'h100,
    parameter int          FB_BYTES  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        scan_busy,
    output logic        frame_done,
    output logic        mem_read,
    output logic [11:0] mem_read_addr,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_read_ack,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [5:0]  pix_x,
    output logic [4:0]  pix_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FB_BYTES - 1);

    state_t      state_r, state_s;
    logic [7:0]  byte_idx_r, byte_idx_s;
    logic [2:0]  bit_pos_r, bit_pos_s;
    logic [7:0]  shift_r, shift_s;
    logic        mem_read_r, mem_read_s;
    logic [11:0] mem_addr_r, mem_addr_s;
    logic        pix_valid_r, pix_valid_s;
    logic        pix_data_r, pix_data_s;
    logic [5:0]  pix_x_r, pix_x_s;
    logic [4:0]  pix_y_r, pix_y_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [7:0]  idx_inc_s;
    logic [2:0]  bit_inc_s;
    logic        ack_s;
`ifdef SCANOUT_PREFETCH_EN
    logic [7:0]  buf_r, buf_s;
    logic        buf_valid_r, buf_valid_s;
    logic        pf_issued_r, pf_issued_s;
`endif

    assign idx_inc_s = byte_idx_r + 8'd1;
    assign bit_inc_s = bit_pos_r + 3'd1;
    // An ack only counts while a read is actually outstanding.
    assign ack_s     = mem_read_ack & mem_read_r;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        byte_idx_s  = byte_idx_r;
        bit_pos_s   = bit_pos_r;
        shift_s     = shift_r;
        mem_read_s  = mem_read_r;
        mem_addr_s  = mem_addr_r;
        pix_valid_s = pix_valid_r;
        pix_data_s  = pix_data_r;
        pix_x_s     = pix_x_r;
        pix_y_s     = pix_y_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
`ifdef SCANOUT_PREFETCH_EN
        buf_s       = buf_r;
        buf_valid_s = buf_valid_r;
        pf_issued_s = pf_issued_r;
`endif
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_s    = FETCH;
                    byte_idx_s = 8'd0;
                    mem_read_s = 1'b1;
                    mem_addr_s = FB_OFFSET;
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            FETCH: begin
                if (ack_s) begin
                    state_s     = SHIFT;
                    mem_read_s  = 1'b0;
                    shift_s     = mem_read_data;
                    pix_data_s  = mem_read_data[7];
                    pix_x_s     = {byte_idx_r[2:0], 3'd0};
                    pix_y_s     = byte_idx_r[7:3];
                    bit_pos_s   = 3'd0;
                    pix_valid_s = 1'b1;
`ifdef SCANOUT_PREFETCH_EN
                    pf_issued_s = 1'b0;
`endif
                end else begin
                    mem_read_s  = 1'b1;
                end
            end
            SHIFT: begin
`ifdef SCANOUT_PREFETCH_EN
                // Background fetch of the following byte into the buffer.
                if (ack_s) begin
                    buf_s       = mem_read_data;
                    buf_valid_s = 1'b1;
                    mem_read_s  = 1'b0;
                end else if (!pf_issued_r && (byte_idx_r != LAST_IDX)) begin
                    mem_read_s  = 1'b1;
                    mem_addr_s  = FB_OFFSET + {4'd0, idx_inc_s};
                    pf_issued_s = 1'b1;
                end else begin
                    pf_issued_s = pf_issued_r;
                end
`endif
                if (pix_ready) begin
                    if (bit_pos_r != 3'd7) begin
                        shift_s    = {shift_r[6:0], 1'b0};
                        pix_data_s = shift_r[6];
                        bit_pos_s  = bit_inc_s;
                        pix_x_s    = {byte_idx_r[2:0], bit_inc_s};
                    end else if (byte_idx_r == LAST_IDX) begin
                        state_s     = DONE;
                        pix_valid_s = 1'b0;
                        done_s      = 1'b1;
                        byte_idx_s  = 8'd0;
                        mem_read_s  = 1'b0;
                    end else begin
                        byte_idx_s = idx_inc_s;
`ifdef SCANOUT_PREFETCH_EN
                        if (buf_valid_r || ack_s) begin
                            // Next byte already here: continue without a bubble.
                            shift_s     = buf_valid_r ? buf_r : mem_read_data;
                            pix_data_s  = buf_valid_r ? buf_r[7] : mem_read_data[7];
                            pix_x_s     = {idx_inc_s[2:0], 3'd0};
                            pix_y_s     = idx_inc_s[7:3];
                            bit_pos_s   = 3'd0;
                            buf_valid_s = 1'b0;
                            pf_issued_s = 1'b0;
                            mem_read_s  = 1'b0;
                        end else begin
                            // Prefetch still outstanding: wait for it in FETCH.
                            state_s     = FETCH;
                            pix_valid_s = 1'b0;
                            mem_read_s  = 1'b1;
                            mem_addr_s  = FB_OFFSET + {4'd0, idx_inc_s};
                            pf_issued_s = 1'b0;
                        end
`else
                        state_s     = FETCH;
                        pix_valid_s = 1'b0;
                        mem_read_s  = 1'b1;
                        mem_addr_s  = FB_OFFSET + {4'd0, idx_inc_s};
`endif
                    end
                end else begin
                    pix_valid_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s     = IDLE;
                mem_read_s  = 1'b0;
                pix_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            byte_idx_r  <= 8'd0;
            bit_pos_r   <= 3'd0;
            shift_r     <= 8'd0;
            mem_read_r  <= 1'b0;
            mem_addr_r  <= 12'd0;
            pix_valid_r <= 1'b0;
            pix_data_r  <= 1'b0;
            pix_x_r     <= 6'd0;
            pix_y_r     <= 5'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            byte_idx_r  <= byte_idx_s;
            bit_pos_r   <= bit_pos_s;
            shift_r     <= shift_s;
            mem_read_r  <= mem_read_s;
            mem_addr_r  <= mem_addr_s;
            pix_valid_r <= pix_valid_s;
            pix_data_r  <= pix_data_s;
            pix_x_r     <= pix_x_s;
            pix_y_r     <= pix_y_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

`ifdef SCANOUT_PREFETCH_EN
    // One-entry prefetch buffer and its bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r       <= 8'd0;
            buf_valid_r <= 1'b0;
            pf_issued_r <= 1'b0;
        end else begin
            buf_r       <= buf_s;
            buf_valid_r <= buf_valid_s;
            pf_issued_r <= pf_issued_s;
        end
    end
`endif

    assign scan_busy     = busy_r;
    assign frame_done    = done_r;
    assign mem_read      = mem_read_r;
    assign mem_read_addr = mem_addr_r;
    assign pix_valid     = pix_valid_r;
    assign pix_data      = pix_data_r;
    assign pix_x         = pix_x_r;
    assign pix_y         = pix_y_r;

endmodule

// File: tb/tb_display_scanout.sv
// Self-checking bench for display_scanout: a memory responder and a pixel sink
// run inside tick(); observed pixels/reads are compared with a frame model.
module tb_display_scanout;

    localparam logic [11:0] OFF = 12'h100;
    localparam int NPIX = 2048;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, scan_busy, frame_done, mem_read;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_read_data;
    logic        mem_read_ack, pix_valid, pix_ready, pix_data;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;

    always #5 clk = ~clk;

    display_scanout dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .scan_busy(scan_busy), .frame_done(frame_done),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y)
    );

    typedef struct packed {
        logic [4:0] y;
        logic [5:0] x;
        logic       d;
    } pix_t;

    int compared = 0;
    int mismatched = 0;
    logic [7:0]  mem_img [0:255];
    pix_t        pix_q[$];
    logic [11:0] rd_q[$];
    int ack_delay, ready_mode, resp_cnt, stall_cnt;
    int done_cnt, stab_err, mem_err, busy_err, overlap_err, gap_cnt, activity;
    bit stray_req, frame_active, prev_stall, prev_rd_wait;
    pix_t prev_pix;
    logic [11:0] prev_addr;

    // Expected pixel k of a frame, straight from the framebuffer layout.
    function automatic pix_t model_pix(input int k);
        pix_t e;
        int b, bp;
        b  = k / 8;
        bp = k % 8;
        e.y = 5'(b / 8);
        e.x = 6'((b % 8) * 8 + bp);
        e.d = mem_img[b][7 - bp];
        return e;
    endfunction

    task automatic clear_obs();
        pix_q.delete();
        rd_q.delete();
        done_cnt = 0; stab_err = 0; mem_err = 0; busy_err = 0;
        overlap_err = 0; gap_cnt = 0; activity = 0;
        prev_stall = 1'b0; prev_rd_wait = 1'b0; resp_cnt = 0; stall_cnt = 0;
    endtask

    // One clock: sample at the falling edge, then drive sink/memory inputs.
    task automatic tick();
        logic [11:0] a;
        pix_t cur;
        @(negedge clk);
        case (ready_mode)
            0: pix_ready = 1'b1;
            1: pix_ready = 1'($urandom_range(0, 1));
            2: begin
                if (pix_valid && pix_x == 6'd3 && pix_y == 5'd0 && stall_cnt < 5) begin
                    pix_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    pix_ready = 1'b1;
                end
            end
            default: pix_ready = 1'b1;
        endcase
        cur.y = pix_y; cur.x = pix_x; cur.d = pix_data;
        if (prev_stall && (!pix_valid || cur !== prev_pix)) stab_err++;
        prev_stall = pix_valid && !pix_ready;
        prev_pix = cur;
        if (pix_valid && pix_ready) pix_q.push_back(cur);
        if (prev_rd_wait && (mem_read !== 1'b1 || mem_read_addr !== prev_addr)) mem_err++;
        if (mem_read_ack) begin
            mem_read_ack = 1'b0;
            prev_rd_wait = 1'b0;
        end else if (stray_req) begin
            mem_read_ack = 1'b1;
            mem_read_data = 8'($urandom);
            stray_req = 1'b0;
            prev_rd_wait = 1'b0;
        end else if (mem_read) begin
            resp_cnt++;
            prev_addr = mem_read_addr;
            if (resp_cnt >= ack_delay) begin
                a = mem_read_addr - OFF;
                mem_read_ack = 1'b1;
                mem_read_data = mem_img[a[7:0]];
                rd_q.push_back(mem_read_addr);
                resp_cnt = 0;
                prev_rd_wait = 1'b0;
            end else begin
                prev_rd_wait = 1'b1;
            end
        end else begin
            resp_cnt = 0;
            prev_rd_wait = 1'b0;
        end
        if (frame_done) begin
            done_cnt++;
            if (!scan_busy) busy_err++;
        end
        if (frame_active && done_cnt == 0 && !scan_busy) busy_err++;
        if (pix_valid && mem_read) overlap_err++;
        if (pix_q.size() > 0 && pix_q.size() < NPIX && !pix_valid) gap_cnt++;
        if (mem_read || pix_valid || scan_busy || frame_done) activity++;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    endtask

    // Scan one whole frame and compare it with the model.
    task automatic run_frame(input int dly, input int rmode, input bit poke);
        int n, shown;
        pix_t e;
        clear_obs();
        ack_delay = dly; ready_mode = rmode;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        compared++;
        if ({mem_read, mem_read_addr, scan_busy} !== {1'b1, OFF, 1'b1}) begin
            mismatched++;
            $display("FAIL start: read/addr/busy=%b/%h/%b want 1/%h/1", mem_read, mem_read_addr, scan_busy, OFF);
        end
        frame_active = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 30000) begin
            frame_start = poke && (n == 300);
            tick();
            n++;
        end
        frame_start = 1'b0;
        frame_active = 1'b0;
        compared++;
        if (done_cnt == 0) begin
            mismatched++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles", n);
        end
        for (int i = 0; i < 20; i++) tick();
        compared++;
        if (done_cnt != 1 || scan_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL frame_done_count: done=%0d busy=%b want 1 and 0", done_cnt, scan_busy);
        end
        compared++;
        if (pix_q.size() != NPIX) begin
            mismatched++;
            $display("FAIL pixel_count: got %0d want %0d", pix_q.size(), NPIX);
        end
        shown = 0;
        for (int k = 0; k < pix_q.size() && k < NPIX; k++) begin
            e = model_pix(k);
            compared++;
            if (pix_q[k] !== e) begin
                mismatched++;
                if (shown < 10) $display("FAIL pixel[%0d]: got y%0d x%0d d%b want y%0d x%0d d%b",
                                         k, pix_q[k].y, pix_q[k].x, pix_q[k].d, e.y, e.x, e.d);
                shown++;
            end
        end
        compared++;
        if (rd_q.size() != 256) begin
            mismatched++;
            $display("FAIL read_count: got %0d want 256", rd_q.size());
        end
        shown = 0;
        for (int k = 0; k < rd_q.size() && k < 256; k++) begin
            compared++;
            if (rd_q[k] !== OFF + 12'(k)) begin
                mismatched++;
                if (shown < 10) $display("FAIL read_addr[%0d]: got %h want %h", k, rd_q[k], OFF + 12'(k));
                shown++;
            end
        end
        compared++;
        if (stab_err != 0 || mem_err != 0 || busy_err != 0) begin
            mismatched++;
            $display("FAIL hold_rules: pix_unstable=%0d read_unstable=%0d busy_low=%0d want 0", stab_err, mem_err, busy_err);
        end
`ifndef SCANOUT_PREFETCH_EN
        compared++;
        if (overlap_err != 0) begin
            mismatched++;
            $display("FAIL valid_in_fetch: %0d cycles with pix_valid and mem_read, want 0", overlap_err);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        compared++;
        if ({mem_read, mem_read_addr, pix_valid, pix_data, pix_x, pix_y, scan_busy, frame_done} !== 28'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0",
                     {mem_read, mem_read_addr, pix_valid, pix_data, pix_x, pix_y, scan_busy, frame_done});
        end
        tick(); tick();
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 5; i++) tick();
        compared++;
        if (activity != 0) begin
            mismatched++;
            $display("FAIL idle_quiet: %0d active cycles want 0", activity);
        end
    endtask

    task automatic test_incrementing();
        for (int i = 0; i < 256; i++) mem_img[i] = 8'(i);
        run_frame(1, 0, 1'b0);
`ifndef SCANOUT_PREFETCH_EN
        compared++;
        if (gap_cnt < 255) begin
            mismatched++;
            $display("FAIL fetch_bubbles: got %0d want >=255", gap_cnt);
        end
`endif
    endtask

    task automatic test_pattern();
        logic [7:0] a5_bits;
        a5_bits = 8'b1010_0101;
        fill_random();
        mem_img[0] = 8'hA5;
        mem_img[9] = 8'h80;
        run_frame(1, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (pix_q.size() <= i || pix_q[i] !== {5'd0, 6'(i), a5_bits[7 - i]}) begin
                mismatched++;
                $display("FAIL byte0_pixel[%0d]: got %h want %h", i,
                         (pix_q.size() > i) ? pix_q[i] : 12'hfff, {5'd0, 6'(i), a5_bits[7 - i]});
            end
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (pix_q.size() <= 72 + i || pix_q[72 + i] !== {5'd1, 6'(8 + i), (i == 0) ? 1'b1 : 1'b0}) begin
                mismatched++;
                $display("FAIL byte9_pixel[%0d]: got %h want %h", i,
                         (pix_q.size() > 72 + i) ? pix_q[72 + i] : 12'hfff, {5'd1, 6'(8 + i), (i == 0) ? 1'b1 : 1'b0});
            end
        end
    endtask

    task automatic test_stall();
        int seen;
        fill_random();
        run_frame(1, 2, 1'b0);
        seen = 0;
        foreach (pix_q[k]) if (pix_q[k].x == 6'd3 && pix_q[k].y == 5'd0) seen++;
        compared++;
        if (stall_cnt != 5 || seen != 1) begin
            mismatched++;
            $display("FAIL stall_pixel: stall_cycles=%0d seen=%0d want 5 and 1", stall_cnt, seen);
        end
    endtask

    task automatic test_slow_ack_and_restart();
        fill_random();
        run_frame(4, 1, 1'b1);
    endtask

    task automatic test_mid_reset();
        int n;
        fill_random();
        clear_obs();
        ack_delay = 6; ready_mode = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!(mem_read && mem_read_addr == OFF + 12'd40) && n < 5000) begin
            tick();
            n++;
        end
        compared++;
        if (n >= 5000) begin
            mismatched++;
            $display("FAIL reach_byte40: no fetch of %h within %0d cycles", OFF + 12'd40, n);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({mem_read, mem_read_addr, pix_valid, pix_data, pix_x, pix_y, scan_busy, frame_done} !== 28'd0) begin
            mismatched++;
            $display("FAIL midframe_reset: got %h want 0",
                     {mem_read, mem_read_addr, pix_valid, pix_data, pix_x, pix_y, scan_busy, frame_done});
        end
        mem_read_ack = 1'b0;
        clear_obs();
        tick(); tick();
        rst_n = 1'b1;
        stray_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        compared++;
        if (activity != 0 || rd_q.size() != 0) begin
            mismatched++;
            $display("FAIL stray_ack: active=%0d reads=%0d want 0 and 0", activity, rd_q.size());
        end
        run_frame(1, 0, 1'b0);
        compared++;
        if (rd_q.size() == 0 || rd_q[0] !== OFF) begin
            mismatched++;
            $display("FAIL restart_addr: got %h want %h", (rd_q.size() > 0) ? rd_q[0] : 12'hfff, OFF);
        end
    endtask

`ifdef SCANOUT_PREFETCH_EN
    task automatic test_prefetch_stream();
        fill_random();
        run_frame(1, 0, 1'b0);
        compared++;
        if (gap_cnt != 0) begin
            mismatched++;
            $display("FAIL stream_gaps: got %0d want 0", gap_cnt);
        end
    endtask
`endif

    initial begin
        frame_start = 1'b0; mem_read_ack = 1'b0; mem_read_data = 8'd0;
        pix_ready = 1'b1; stray_req = 1'b0; frame_active = 1'b0;
        ack_delay = 1; ready_mode = 0;
        clear_obs();
        test_reset();
        test_incrementing();
        test_pattern();
        test_stall();
        test_slow_ack_and_restart();
        test_mid_reset();
`ifdef SCANOUT_PREFETCH_EN
        test_prefetch_stream();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_scanout.md
DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 SHALL have parameter FB_OFFSET, default 12'h100, base address of the framebuffer in memory.
REQ-002 SHALL have parameter FB_BYTES, default 256, number of bytes in one frame (64x32 pixels, 8 bytes per row).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port frame_start  input  1  single-cycle request to scan one frame.
REQ-006 SHALL have port scan_busy  output  1  high from frame acceptance until frame_done.
REQ-007 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-008 SHALL have port mem_read  output  1  memory read request.
REQ-009 SHALL have port mem_read_addr  output  12  memory read address.
REQ-010 SHALL have port mem_read_data  input  8  read data, valid in the cycle mem_read_ack is high.
REQ-011 SHALL have port mem_read_ack  input  1  read completion strobe.
REQ-012 SHALL have port pix_valid  output  1  pixel output valid.
REQ-013 SHALL have port pix_ready  input  1  downstream accepts the pixel when high together with pix_valid.
REQ-014 SHALL have port pix_data  output  1  pixel value, 1 = lit.
REQ-015 SHALL have port pix_x  output  6  pixel column, 0-63.
REQ-016 SHALL have port pix_y  output  5  pixel row, 0-31.

Function
REQ-017 SHALL implement states IDLE, FETCH, SHIFT and DONE.
REQ-018 In IDLE, frame_start high SHALL set the byte index to 0 and enter FETCH; mem_read SHALL go high in the next cycle.
REQ-019 In FETCH, the block SHALL hold mem_read high and mem_read_addr = FB_OFFSET + byte index (12-bit, no overflow for defaults) stable until mem_read_ack.
REQ-020 On mem_read_ack, the block SHALL latch mem_read_data into the shift register, drop mem_read the next cycle and enter SHIFT.
REQ-021 In SHIFT, the block SHALL present 8 pixels MSB first; pix_data/pix_x/pix_y SHALL stay stable while pix_valid is high and pix_ready is low.
REQ-022 Pixel coordinates SHALL be pix_x = {byte_index[2:0], bit position 0-7} and pix_y = byte_index[7:3].
REQ-023 After the 8th pixel is accepted, the block SHALL increment the byte index and enter FETCH, or DONE if the index was FB_BYTES-1.
REQ-024 DONE SHALL pulse frame_done for one cycle and return to IDLE; the byte index SHALL wrap to 0.
REQ-025 frame_start while scan_busy is high SHALL be ignored; no queuing.
REQ-026 mem_read_ack outside FETCH (or without mem_read) SHALL be ignored.
REQ-027 pix_valid SHALL be low in IDLE, FETCH (non-prefetch build) and DONE.
REQ-028 scan_busy SHALL be high in FETCH, SHIFT and DONE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, even mid-frame or mid-read.
REQ-030 rst_n low SHALL immediately force all outputs (mem_read, mem_read_addr, pix_valid, pix_data, pix_x, pix_y, scan_busy, frame_done) and the byte index to 0.
REQ-031 An outstanding read abandoned by reset SHALL NOT be reissued; a late ack SHALL be ignored per REQ-026.

Configuration
REQ-032 Macro SCANOUT_PREFETCH_EN defined: the block SHALL issue the read for byte index+1 while shifting the current byte and hold the returned byte in a one-entry buffer.
REQ-033 With SCANOUT_PREFETCH_EN defined and the buffer filled before the 8th pixel is accepted, the next pixel SHALL be valid in the following cycle (zero-bubble stream); no prefetch SHALL be issued past FB_BYTES-1.
REQ-034 Macro SCANOUT_PREFETCH_EN undefined: there SHALL be no prefetch and no buffer; each byte incurs its FETCH latency with pix_valid low.

Verification
REQ-035 Reset, then pulse frame_start, ack each read after 1 cycle with data = low byte of address, pix_ready tied high -> 256 reads at 0x100..0x1FF in order, 2048 pixels, frame_done one pulse.
REQ-036 Byte 0 data 8'hA5 -> pixels (x 0-7, y 0) = 1,0,1,0,0,1,0,1; byte 9 data 8'h80 -> pixel (x=8, y=1) = 1, x 9-15 = 0.
REQ-037 Hold pix_ready low 5 cycles on pixel (3,0) -> pix_valid and the outputs stay stable, no skipped or duplicated pixel.
REQ-038 Delay ack 4 cycles -> mem_read and mem_read_addr stay stable for all 4 cycles; frame_start during the scan -> ignored, single frame_done.
REQ-039 Drop rst_n during FETCH of byte 40 -> outputs 0 and state IDLE immediately; a stray ack afterwards causes no activity; a new frame_start then begins at 0x100.
REQ-040 With SCANOUT_PREFETCH_EN defined, 1-cycle acks and pix_ready high -> pix_valid continuous from the first pixel to the 2048th.
